imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the instruction memory. The single-cycle CPU only reads instruction memory by PC; this block fills it with a program image.
- Accepts a framed byte stream on a valid/ready handshake and assembles 16-bit instruction words.
- Writes the words to consecutive instruction-memory addresses starting at 0, then verifies a checksum.
- Holds the CPU (cpu_hold) during the load and releases it only after a clean load.

Parameters:
ISIZE, 16, instruction/address width (matches PC width)
DSIZE, 16, data word width written to memory
MAX_WORDS, 256, largest accepted word count
SYNC_BYTE, 8'hA5, frame start marker

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
start  input  1  one-cycle pulse: arm or restart a load
in_valid  input  1  in_data holds a byte
in_data  input  8  stream byte
in_ready  output  1  loader accepts byte this cycle (combinational)
mem_wen  output  1  instruction-memory write enable, one-cycle pulse
mem_addr  output  ISIZE  write address (word index)
mem_wdata  output  DSIZE  write data {hi,lo}
cpu_hold  output  1  holds CPU/PC while high
done  output  1  sticky, set on a clean load
error  output  1  sticky, set on a bad count or bad checksum
words_loaded  output  ISIZE  count of words written in the current load

Behaviour:
- Frame format: SYNC_BYTE, CNT_HI, CNT_LO, then N words each sent as hi byte then lo byte, then CHK.
  - CHK = XOR of CNT_HI, CNT_LO and all data bytes. SYNC_BYTE and CHK are excluded.
- A byte is accepted only in a cycle with in_valid & in_ready.
- in_ready = 1 only in states SYNC..CHECK, and only when start=0 and rst=0.
- Reset: state IDLE; in_ready, mem_wen, cpu_hold, done, error = 0; mem_addr, mem_wdata, words_loaded = 0; internal count and checksum = 0.
- IDLE:
  - Loader is inactive.
  - start -> SYNC; set cpu_hold=1; clear done, error, addr, words_loaded, checksum.
- SYNC:
  - Accepted byte == SYNC_BYTE -> CNT_HI.
  - Any other byte is discarded and the state stays SYNC.
- CNT_HI: latch count[15:8], fold into checksum -> CNT_LO.
- CNT_LO: latch count[7:0], fold into checksum, then:
  - count == 0 -> CHECK.
  - count > MAX_WORDS -> ERR.
  - otherwise -> DATA_HI.
- DATA_HI: latch hi byte, fold into checksum -> DATA_LO.
- DATA_LO: accept lo byte, fold into checksum.
  - Next cycle: mem_wen=1 for exactly one cycle, mem_addr=addr, mem_wdata={hi,lo}.
  - Same edge as the pulse: addr and words_loaded increment.
  - If the new word count equals count -> CHECK, else -> DATA_HI.
- Write timing:
  - The next byte may be accepted in the same cycle as the mem_wen pulse; no stall is required.
  - mem_addr and mem_wdata hold their last values between pulses.
- CHECK:
  - Accepted byte == checksum -> DONE.
  - Otherwise -> ERR.
- DONE: done=1, cpu_hold=0 from the cycle after CHK is accepted. Stays until start.
- ERR: error=1, cpu_hold stays 1 (CPU is not released on a bad image), in_ready=0. Only start re-arms the loader.
- Error handling: words already written before an error are not rolled back.
- start in any non-IDLE state:
  - Aborts the load and goes to SYNC with the same clears as from IDLE.
  - Any byte offered that cycle is not accepted.
- rst mid-load: returns to the reset state next edge, including cpu_hold=0. A pending write pulse is cancelled.
- Arithmetic:
  - addr and words_loaded are ISIZE wide.
  - Since count ≤ MAX_WORDS ≤ 2^ISIZE, addr never wraps.
  - The checksum is 8-bit XOR.
- in_valid may drop between any bytes. The FSM simply waits, with no timeout.

Test Plan:
- Test 1, clean load with gaps: rst, then start, then stream A5 00 02 12 34 AB CD 42 with in_valid gaps.
  - Expect writes (addr0, 0x1234) and (addr1, 0xABCD), each mem_wen exactly one cycle.
  - Expect words_loaded=2, done=1, error=0, cpu_hold 1→0 the cycle after 0x42 is accepted.
- Test 2, bad checksum: same stream with CHK=0x43.
  - Expect both writes still to occur, error=1, done=0, cpu_hold stays 1, in_ready=0.
- Test 3, leading garbage: start, then 00 FF 5A, then the scenario-1 frame.
  - Expect the garbage bytes accepted and dropped, and results identical to scenario 1.
- Test 4, count bounds:
  - A5 00 00 00 → done=1 with no mem_wen.
  - A5 01 01 (257 > MAX_WORDS) → error=1 right after CNT_LO, with no mem_wen.
- Test 5, restart: start pulse after the first word of scenario 1 has been written.
  - Expect in_ready=0 in that cycle, state back to SYNC, addr=0.
  - Re-sending the full frame gives writes to addr0/addr1 and done=1.
- Test 6, reset mid-load: rst asserted between DATA_HI and DATA_LO.
  - Expect all outputs 0 next cycle, no mem_wen, and in_ready=0 until a new start.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: fills instruction memory from a framed byte stream (SYNC, CNT_HI, CNT_LO, N x {hi,lo}, CHK).
// Latency: each word is written one cycle after its lo byte is accepted; done/error are registered one cycle after the deciding byte.
// Backpressure: in_ready is combinational, high only in SYNC..CHECK with start=0 and rst=0; no stall is needed around write pulses.
module imem_loader #(
   parameter int         ISIZE     = 16,
   parameter int         DSIZE     = 16,
   parameter int         MAX_WORDS = 256,
   parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   output logic             in_ready,
   output logic             mem_wen,
   output logic [ISIZE-1:0] mem_addr,
   output logic [DSIZE-1:0] mem_wdata,
   output logic             cpu_hold,
   output logic             done,
   output logic             error,
   output logic [ISIZE-1:0] words_loaded
);

   typedef enum logic [3:0] {
      IDLE, SYNC, CNT_HI, CNT_LO, DATA_HI, DATA_LO, CHECK, DONE, ERR
   } state_t;

   state_t           state;
   logic [15:0]      count;
   logic [7:0]       chk;
   logic [7:0]       hi_byte;
   logic [15:0]      cnt_full;
   logic [ISIZE-1:0] wl_next;
   logic             acc;

   // words_loaded doubles as the next write address, so one counter serves both
   assign wl_next  = words_loaded + ISIZE'(1);
   assign cnt_full = {count[15:8], in_data};
   assign acc      = in_valid & in_ready;

   // Accept bytes only while parsing a frame and never in a start or reset cycle
   always_comb begin
      in_ready = 1'b0;
      case (state)
         SYNC, CNT_HI, CNT_LO, DATA_HI, DATA_LO, CHECK: in_ready = ~start & ~rst;
         default:                                       in_ready = 1'b0;
      endcase
   end

   // Frame parser: start has priority over any byte and re-arms from every state
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         mem_wen      <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         cpu_hold     <= 1'b0;
         done         <= 1'b0;
         error        <= 1'b0;
         words_loaded <= '0;
         count        <= '0;
         chk          <= '0;
         hi_byte      <= '0;
      end else begin
         mem_wen <= 1'b0;
         if (start) begin
            state        <= SYNC;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            chk          <= '0;
         end else if (acc) begin
            case (state)
               SYNC: begin
                  if (in_data == SYNC_BYTE) state <= CNT_HI;
               end
               CNT_HI: begin
                  count[15:8] <= in_data;
                  chk         <= chk ^ in_data;
                  state       <= CNT_LO;
               end
               CNT_LO: begin
                  count[7:0] <= in_data;
                  chk        <= chk ^ in_data;
                  if (cnt_full == 16'd0) begin
                     state <= CHECK;
                  end else if (cnt_full > 16'(MAX_WORDS)) begin
                     state <= ERR;
                     error <= 1'b1;
                  end else begin
                     state <= DATA_HI;
                  end
               end
               DATA_HI: begin
                  hi_byte <= in_data;
                  chk     <= chk ^ in_data;
                  state   <= DATA_LO;
               end
               DATA_LO: begin
                  chk          <= chk ^ in_data;
                  mem_wen      <= 1'b1;
                  mem_addr     <= words_loaded;
                  mem_wdata    <= DSIZE'({hi_byte, in_data});
                  words_loaded <= wl_next;
                  state        <= (wl_next == ISIZE'(count)) ? CHECK : DATA_HI;
               end
               CHECK: begin
                  if (in_data == chk) begin
                     state    <= DONE;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                  end else begin
                     // CPU stays held on a bad image
                     state <= ERR;
                     error <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed frames plus random frames checked against a frame-parsing reference model.
module tb_imem_loader;
   typedef logic [7:0]  bq_t[$];
   typedef logic [31:0] wq_t[$];

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_ready, mem_wen, cpu_hold, done, error;
   logic [15:0] mem_addr, mem_wdata, words_loaded;

   int total = 0;
   int bad = 0;
   logic [31:0] wr_seen[$];

   always #5 clk = ~clk;

   imem_loader dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_hold(cpu_hold), .done(done), .error(error), .words_loaded(words_loaded)
   );

   // record every write-enable cycle; a stretched pulse shows up as an extra entry
   always @(negedge clk) if (mem_wen) wr_seen.push_back({mem_addr, mem_wdata});

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      check(tag, {31'd0, obs}, {31'd0, exp});
   endtask

   // reference: locate the sync byte, read the count, pair up data bytes, xor-verify
   task automatic model(input bq_t s, output wq_t w, output logic d, output logic e, output int nw);
      int i;
      int cnt;
      logic [7:0] x;
      i = 0; w.delete(); d = 1'b0; e = 1'b0; nw = 0;
      while (s[i] != 8'hA5) i++;
      cnt = int'({s[i+1], s[i+2]});
      x = s[i+1] ^ s[i+2];
      i += 3;
      if (cnt > 256) begin
         e = 1'b1;
         return;
      end
      for (int k = 0; k < cnt; k++) begin
         w.push_back({16'(k), s[i], s[i+1]});
         x ^= s[i] ^ s[i+1];
         i += 2;
      end
      nw = cnt;
      d = (s[i] == x);
      e = ~d;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      in_valid = 1'b1; in_data = b; #1;
      while (!in_ready && n < 40) begin
         @(negedge clk); #1; n++;
      end
      if (!in_ready) chk1("accept_timeout", in_ready, 1'b1);
      @(negedge clk);
      in_valid = 1'b0; in_data = 8'h00;
   endtask

   task automatic pulse_start(input string tag);
      @(negedge clk); start = 1'b1; #1;
      chk1({tag, ".start_rdy"}, in_ready, 1'b0);
      @(negedge clk); start = 1'b0; #1;
      chk1({tag, ".hold_on"}, cpu_hold, 1'b1);
      chk1({tag, ".done_clr"}, done, 1'b0);
      chk1({tag, ".err_clr"}, error, 1'b0);
      check({tag, ".wl_clr"}, {16'd0, words_loaded}, 32'd0);
   endtask

   task automatic run_frame(input string tag, input bq_t s, input bit do_start);
      wq_t w;
      logic d, e;
      int nw;
      model(s, w, d, e, nw);
      if (do_start) pulse_start(tag);
      wr_seen.delete();
      for (int i = 0; i < s.size() - 1; i++) send_byte(s[i]);
      chk1({tag, ".hold_mid"}, cpu_hold, 1'b1);
      send_byte(s[s.size() - 1]);
      chk1({tag, ".done"}, done, d);
      chk1({tag, ".error"}, error, e);
      chk1({tag, ".hold"}, cpu_hold, ~d);
      chk1({tag, ".rdy_end"}, in_ready, 1'b0);
      repeat (3) @(negedge clk);
      #1;
      check({tag, ".nwr"}, 32'(wr_seen.size()), 32'(w.size()));
      for (int i = 0; i < w.size(); i++)
         check({tag, ".wr"}, (i < wr_seen.size()) ? wr_seen[i] : 32'hxxxxxxxx, w[i]);
      check({tag, ".wl"}, {16'd0, words_loaded}, 32'(nw));
      chk1({tag, ".sticky"}, done, d);
   endtask

   function automatic bq_t frame1(input logic [7:0] c);
      bq_t s;
      s.push_back(8'hA5); s.push_back(8'h00); s.push_back(8'h02);
      s.push_back(8'h12); s.push_back(8'h34); s.push_back(8'hAB); s.push_back(8'hCD);
      s.push_back(c);
      return s;
   endfunction

   initial begin
      bq_t s;
      logic [7:0] b, x;
      int cnt;

      // reset state
      repeat (3) @(negedge clk);
      #1;
      chk1("rst.in_ready", in_ready, 1'b0);
      chk1("rst.mem_wen", mem_wen, 1'b0);
      chk1("rst.cpu_hold", cpu_hold, 1'b0);
      chk1("rst.done", done, 1'b0);
      chk1("rst.error", error, 1'b0);
      check("rst.addr", {16'd0, mem_addr}, 32'd0);
      check("rst.wdata", {16'd0, mem_wdata}, 32'd0);
      check("rst.wl", {16'd0, words_loaded}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // clean load, bad checksum, leading garbage
      run_frame("t1", frame1(8'h42), 1'b1);
      run_frame("t2", frame1(8'h43), 1'b1);
      s = frame1(8'h42);
      s.push_front(8'h5A); s.push_front(8'hFF); s.push_front(8'h00);
      run_frame("t3", s, 1'b1);

      // count bounds
      s.delete();
      s.push_back(8'hA5); s.push_back(8'h00); s.push_back(8'h00); s.push_back(8'h00);
      run_frame("t4zero", s, 1'b1);
      s.delete();
      s.push_back(8'hA5); s.push_back(8'h01); s.push_back(8'h01);
      run_frame("t4big", s, 1'b1);

      // restart after the first word has been written
      s = frame1(8'h42);
      pulse_start("t5a");
      wr_seen.delete();
      for (int i = 0; i < 5; i++) send_byte(s[i]);
      #1;
      chk1("t5.wen_first", mem_wen, 1'b1);
      check("t5.wl_first", {16'd0, words_loaded}, 32'd1);
      in_valid = 1'b1; in_data = 8'hAB;
      pulse_start("t5b");
      in_valid = 1'b0;
      run_frame("t5", s, 1'b0);

      // random frames, some with a corrupted checksum
      for (int r = 0; r < 6; r++) begin
         s.delete();
         repeat ($urandom_range(0, 2)) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h5A;
            s.push_back(b);
         end
         cnt = $urandom_range(1, 6);
         s.push_back(8'hA5); s.push_back(8'h00); s.push_back(8'(cnt));
         x = 8'(cnt);
         for (int k = 0; k < 2 * cnt; k++) begin
            b = 8'($urandom_range(0, 255));
            s.push_back(b);
            x ^= b;
         end
         if ($urandom_range(0, 1) == 1) x ^= 8'h01 << $urandom_range(0, 7);
         s.push_back(x);
         run_frame("rnd", s, 1'b1);
      end

      // reset between DATA_HI and DATA_LO
      s = frame1(8'h42);
      pulse_start("t6");
      wr_seen.delete();
      for (int i = 0; i < 4; i++) send_byte(s[i]);
      rst = 1'b1; in_valid = 1'b1; in_data = 8'h34; #1;
      chk1("t6.rdy_in_rst", in_ready, 1'b0);
      @(negedge clk);
      rst = 1'b0; in_data = 8'hA5; #1;
      chk1("t6.in_ready", in_ready, 1'b0);
      chk1("t6.mem_wen", mem_wen, 1'b0);
      chk1("t6.cpu_hold", cpu_hold, 1'b0);
      chk1("t6.done", done, 1'b0);
      chk1("t6.error", error, 1'b0);
      check("t6.addr", {16'd0, mem_addr}, 32'd0);
      check("t6.wdata", {16'd0, mem_wdata}, 32'd0);
      check("t6.wl", {16'd0, words_loaded}, 32'd0);
      repeat (3) @(negedge clk);
      #1;
      chk1("t6.rdy_idle", in_ready, 1'b0);
      check("t6.nwr", 32'(wr_seen.size()), 32'd0);
      in_valid = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
